// File: rtl/seq_ctrl_pkg.sv
// Shared types and helpers for the serial stream sequencer.
package seq_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned DEF_CNT_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Zero or an over-long request means a full-width run.
  function automatic int unsigned effective_len(input int unsigned len, input int unsigned width);
    return ((len == 32'd0) || (len > width)) ? width : len;
  endfunction

endpackage

// File: rtl/serial_stream_sequencer.sv
// Streams a latched pattern MSB-first into a serial detector and tallies
// the detector's responses (hit count, first hit position).
module serial_stream_sequencer
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] len,
  output logic             det_x,
  output logic             det_rst,
  input  logic             det_y,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] first_hit_idx,
  output logic             first_hit_valid
);

  // Remaining counter must hold WIDTH itself, independent of CNT_W.
  localparam int unsigned REM_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] idx_dly_q;
  logic             issued_q;
  logic             clear_c;

  // Next-state, datapath next values and run-accept strobe.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    clear_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_INIT;
          shreg_d = pattern;
          rem_d   = REM_W'(effective_len(32'(len), WIDTH));
          idx_d   = '0;
          clear_c = 1'b1;
        end
      end
      ST_INIT:   state_d = ST_STREAM;
      ST_STREAM: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        rem_d   = rem_q - REM_W'(1);
        idx_d   = idx_q + CNT_W'(1);
        if (rem_q == REM_W'(1)) state_d = ST_DRAIN;
      end
      ST_DRAIN:  state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Detector is held in reset with the block and for the INIT cycle.
  assign det_rst = ~rst | (state_q == ST_INIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      idx_dly_q <= '0;
      issued_q  <= 1'b0;
      det_x     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      idx_dly_q <= idx_q;
      issued_q  <= (state_q == ST_STREAM);
      det_x     <= (state_d == ST_STREAM) ? shreg_d[WIDTH-1] : 1'b0;
      busy      <= (state_d != ST_IDLE);
      done      <= (state_d == ST_DONE);
    end
  end

  // det_y answers the bit issued one cycle earlier, so qualify with the delayed flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count       <= '0;
      first_hit_idx   <= '0;
      first_hit_valid <= 1'b0;
    end else if (clear_c) begin
      hit_count       <= '0;
      first_hit_idx   <= '0;
      first_hit_valid <= 1'b0;
    end else if (issued_q && det_y) begin
      if (hit_count != CNT_MAX) hit_count <= hit_count + CNT_W'(1);
      if (!first_hit_valid) begin
        first_hit_valid <= 1'b1;
        first_hit_idx   <= idx_dly_q;
      end
    end
  end

endmodule

// File: tb/tb_serial_stream_sequencer.sv
// Directed bench for serial_stream_sequencer with a "11" detector model.
module tb_serial_stream_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] pattern;
  logic [6:0]  len;
  logic        det_x, det_rst, det_y, busy, done, first_hit_valid;
  logic [6:0]  hit_count, first_hit_idx;

  logic        s_start;
  logic        s_det_x, s_det_rst, s_busy, s_done, s_first_hit_valid;
  logic [5:0]  s_hit_count, s_first_hit_idx;

  logic        m_prev;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int hits;
    int idx;
    bit valid;
  } exp_t;

  exp_t sb[$];

  serial_stream_sequencer #(.WIDTH(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
    .det_x(det_x), .det_rst(det_rst), .det_y(det_y), .busy(busy), .done(done),
    .hit_count(hit_count), .first_hit_idx(first_hit_idx),
    .first_hit_valid(first_hit_valid)
  );

  serial_stream_sequencer #(.WIDTH(64), .CNT_W(6)) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .pattern(64'h0), .len(6'd0),
    .det_x(s_det_x), .det_rst(s_det_rst), .det_y(1'b1), .busy(s_busy), .done(s_done),
    .hit_count(s_hit_count), .first_hit_idx(s_first_hit_idx),
    .first_hit_valid(s_first_hit_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Moore "11" detector: output reflects the bit applied in the previous cycle.
  always @(posedge clk) begin
    if (det_rst) begin
      m_prev <= 1'b0;
      det_y  <= 1'b0;
    end else begin
      det_y  <= m_prev & det_x;
      m_prev <= det_x;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  function automatic int eff_len(input int ln);
    return (ln == 0 || ln > 64) ? 64 : ln;
  endfunction

  // Expected detector results for a stream of L bits of pat, MSB first.
  function automatic exp_t ref_model(input logic [63:0] pat, input int l, input int maxc);
    exp_t r;
    r.hits = 0; r.idx = 0; r.valid = 1'b0;
    for (int k = 1; k < l; k++) begin
      if (pat[63-k] && pat[64-k]) begin
        if (r.hits < maxc) r.hits++;
        if (!r.valid) begin r.valid = 1'b1; r.idx = k; end
      end
    end
    return r;
  endfunction

  task automatic run_seq(input string name, input logic [63:0] pat, input logic [6:0] ln,
                         input bit spur);
    int   l, cyc, bi;
    bit   seen;
    exp_t e;
    l = eff_len(int'(ln));
    sb.push_back(ref_model(pat, l, 127));
    e = '{hits: 0, idx: 0, valid: 1'b0};
    start = 1'b1; pattern = pat; len = ln;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; seen = 1'b0;
    while (!seen && cyc <= l + 8) begin
      chk({name, "_busy"}, busy, (cyc <= l + 3));
      if (cyc == 1) chk({name, "_init_det_rst"}, det_rst, 1'b1);
      if (cyc == 1 || cyc == l + 2) chk({name, "_det_x_quiet"}, det_x, 1'b0);
      else if (cyc >= 2 && cyc <= l + 1) begin
        bi = 65 - cyc;
        chk({name, "_det_x"}, det_x, pat[bi]);
      end
      chk({name, "_done"}, done, (cyc == l + 3));
      if (done) begin
        seen = 1'b1;
        if (sb.size() > 0) e = sb.pop_front();
        chk({name, "_hit_count"}, hit_count, e.hits);
        chk({name, "_first_idx"}, first_hit_idx, e.idx);
        chk({name, "_first_valid"}, first_hit_valid, e.valid);
      end
      start = spur && (cyc == 3);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({name, "_done_seen"}, seen, 1'b1);
    if (!seen) sb.delete();
    repeat (3) begin
      chk({name, "_post_busy"}, busy, 1'b0);
      chk({name, "_post_done"}, done, 1'b0);
      chk({name, "_hold_hits"}, hit_count, e.hits);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [63:0] rpat;
    int cyc;
    bit seen;

    rst = 1'b0; start = 1'b0; s_start = 1'b0; pattern = '0; len = '0;
    #2;
    chk("rst_det_rst", det_rst, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_det_x", det_x, 1'b0);
    chk("rst_hits", hit_count, 7'd0);
    chk("rst_valid", first_hit_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", busy, 1'b0);
      chk("idle_det_rst", det_rst, 1'b0);
    end

    run_seq("order", 64'h3300_0000_0000_0000, 7'd8, 1'b0);
    chk("order_spec_hits", hit_count, 7'd2);
    chk("order_spec_idx", first_hit_idx, 7'd3);

    rpat = {$urandom, $urandom};
    run_seq("len0", rpat, 7'd0, 1'b0);
    run_seq("len100", rpat, 7'd100, 1'b0);
    run_seq("len1", 64'h8000_0000_0000_0000, 7'd1, 1'b0);
    run_seq("spur", 64'hFFFF_FFFF_FFFF_FFFF, 7'd5, 1'b1);

    // Abort mid-stream after the first hit has been recorded.
    start = 1'b1; pattern = 64'h3300_0000_0000_0000; len = 7'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort_pre_hits", hit_count, 7'd1);
    chk("abort_pre_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_det_rst", det_rst, 1'b1);
    chk("abort_hits", hit_count, 7'd0);
    chk("abort_idx", first_hit_idx, 7'd0);
    chk("abort_valid", first_hit_valid, 1'b0);
    chk("abort_det_x", det_x, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("abort_no_done", done, 1'b0);
      chk("abort_idle", busy, 1'b0);
    end

    run_seq("recover", 64'hF0F0_F0F0_F0F0_F0F0, 7'd0, 1'b0);

    // Saturation on the narrow-count instance with det_y tied high.
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    cyc = 1; seen = 1'b0;
    while (!seen && cyc < 80) begin
      if (s_done) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("sat_done_seen", seen, 1'b1);
    chk("sat_done_cycle", cyc, 67);
    chk("sat_hits", s_hit_count, 6'd63);
    chk("sat_idx", s_first_hit_idx, 6'd0);
    chk("sat_valid", s_first_hit_valid, 1'b1);
    @(negedge clk);
    chk("sat_post_busy", s_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
